led_serial_receiver: RTL

//  Receiving end of the two-wire LED strip link (data + clock, 24-bit RGB per LED, MSB first, frame

---
 rtl/led_serial_receiver_if.sv | 29 ++
 rtl/led_serial_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_serial_receiver_if.sv
// Bundles the strip link, pixel/frame outputs and frame-buffer read port of led_serial_receiver.
interface led_serial_receiver_if #(
  parameter int LEDS = 50
) ();
  localparam int IDX_W = $clog2(LEDS);
  localparam int LEN_W = $clog2(LEDS + 1);

  logic             dIn;
  logic             clkIn;
  logic             pxValid;
  logic [IDX_W-1:0] pxIndex;
  logic [23:0]      pxData;
  logic             frameDone;
  logic [LEN_W-1:0] frameLen;
  logic             frameErr;
  logic             busy;
  logic [IDX_W-1:0] rdAddr;
  logic [23:0]      rdData;

  modport master (
    output dIn, clkIn, rdAddr,
    input  pxValid, pxIndex, pxData, frameDone, frameLen, frameErr, busy, rdData
  );

  modport slave (
    input  dIn, clkIn, rdAddr,
    output pxValid, pxIndex, pxData, frameDone, frameLen, frameErr, busy, rdData
  );
endinterface

// File: rtl/led_serial_receiver.sv
// Two-wire LED strip receiver: assembles 24-bit pixels, ends frames on line-idle timeout.
// Optional frame buffer enabled by defining LEDRX_FRAMEBUF_EN.
module led_serial_receiver #(
  parameter int LEDS         = 50,
  parameter int LATCH_CYCLES = 6250,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  led_serial_receiver_if.slave bus
);
  localparam int IDX_W  = $clog2(LEDS);
  localparam int LEN_W  = $clog2(LEDS + 1);
  localparam int IDLE_W = $clog2(LATCH_CYCLES);
  localparam logic [LEN_W-1:0]  LEDS_L    = LEN_W'(LEDS);
  localparam logic [IDLE_W-1:0] IDLE_TERM = IDLE_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] din_sync_r;
  logic [SYNC_STAGES-1:0] clkin_sync_r;
  logic                   clkin_dly_r;
  logic                   din_s;
  logic                   rise_s;

  state_t            state_r, state_s;
  logic [4:0]        bit_cnt_r, bit_cnt_s;
  logic [LEN_W-1:0]  led_idx_r, led_idx_s;
  logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_s;
  logic              overflow_r, overflow_s;
  logic [23:0]       sh_reg_r, sh_reg_s;
  logic [23:0]       shifted_s;

  logic              px_valid_r, px_valid_s;
  logic [IDX_W-1:0]  px_index_r, px_index_s;
  logic [23:0]       px_data_r, px_data_s;
  logic              frame_done_r, frame_done_s;
  logic [LEN_W-1:0]  frame_len_r, frame_len_s;
  logic              frame_err_r, frame_err_s;
  logic              busy_r, busy_s;
  logic [23:0]       rd_data_r;

  // Synchronise link pins; rise is detected one stage past the synchroniser output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_sync_r   <= '0;
      clkin_sync_r <= '0;
      clkin_dly_r  <= 1'b0;
    end else begin
      din_sync_r   <= {din_sync_r[SYNC_STAGES-2:0], bus.dIn};
      clkin_sync_r <= {clkin_sync_r[SYNC_STAGES-2:0], bus.clkIn};
      clkin_dly_r  <= clkin_sync_r[SYNC_STAGES-1];
    end
  end

  assign din_s     = din_sync_r[SYNC_STAGES-1];
  assign rise_s    = clkin_sync_r[SYNC_STAGES-1] & ~clkin_dly_r;
  assign shifted_s = {sh_reg_r[22:0], din_s};

  // Next-state and next-output logic for the receive FSM.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    led_idx_s    = led_idx_r;
    idle_cnt_s   = idle_cnt_r;
    overflow_s   = overflow_r;
    sh_reg_s     = sh_reg_r;
    px_valid_s   = 1'b0;
    px_index_s   = px_index_r;
    px_data_s    = px_data_r;
    frame_done_s = 1'b0;
    frame_len_s  = frame_len_r;
    frame_err_s  = frame_err_r;
    case (state_r)
      ST_IDLE, ST_RECV: begin
        if (rise_s) begin
          state_s    = ST_RECV;
          idle_cnt_s = '0;
          sh_reg_s   = shifted_s;
          if (bit_cnt_r == 5'd23) begin
            bit_cnt_s = 5'd0;
            if (led_idx_r < LEDS_L) begin
              px_valid_s = 1'b1;
              px_index_s = led_idx_r[IDX_W-1:0];
              px_data_s  = shifted_s;
              led_idx_s  = led_idx_r + LEN_W'(1);
            end else begin
              overflow_s = 1'b1;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end else if (state_r == ST_RECV && idle_cnt_r == IDLE_TERM) begin
          // frameLen/frameErr are loaded together with the frameDone pulse
          state_s      = ST_LATCH;
          idle_cnt_s   = '0;
          frame_done_s = 1'b1;
          frame_len_s  = led_idx_r;
          frame_err_s  = (bit_cnt_r != 5'd0) | overflow_r;
        end else if (state_r == ST_RECV) begin
          idle_cnt_s = idle_cnt_r + IDLE_W'(1);
        end else begin
          idle_cnt_s = '0;
        end
      end
      ST_LATCH: begin
        led_idx_s  = '0;
        overflow_s = 1'b0;
        idle_cnt_s = '0;
        if (rise_s) begin
          state_s   = ST_RECV;
          sh_reg_s  = {23'h0, din_s};
          bit_cnt_s = 5'd1;
        end else begin
          state_s   = ST_IDLE;
          sh_reg_s  = 24'h0;
          bit_cnt_s = 5'd0;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        bit_cnt_s  = 5'd0;
        led_idx_s  = '0;
        idle_cnt_s = '0;
        overflow_s = 1'b0;
        sh_reg_s   = 24'h0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 5'd0;
      led_idx_r    <= '0;
      idle_cnt_r   <= '0;
      overflow_r   <= 1'b0;
      sh_reg_r     <= 24'h0;
      px_valid_r   <= 1'b0;
      px_index_r   <= '0;
      px_data_r    <= 24'h0;
      frame_done_r <= 1'b0;
      frame_len_r  <= '0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      led_idx_r    <= led_idx_s;
      idle_cnt_r   <= idle_cnt_s;
      overflow_r   <= overflow_s;
      sh_reg_r     <= sh_reg_s;
      px_valid_r   <= px_valid_s;
      px_index_r   <= px_index_s;
      px_data_r    <= px_data_s;
      frame_done_r <= frame_done_s;
      frame_len_r  <= frame_len_s;
      frame_err_r  <= frame_err_s;
      busy_r       <= busy_s;
    end
  end

`ifdef LEDRX_FRAMEBUF_EN
  logic [23:0] fbuf_r [LEDS];

  // Frame buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (px_valid_r) begin
      fbuf_r[px_index_r] <= px_data_r;
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 24'h0;
    end else if (int'(bus.rdAddr) < LEDS) begin
      rd_data_r <= fbuf_r[bus.rdAddr];
    end else begin
      rd_data_r <= 24'h0;
    end
  end
`else
  logic unused_rd_addr_s;
  assign unused_rd_addr_s = ^bus.rdAddr;
  assign rd_data_r        = 24'h0;
`endif

  assign bus.pxValid   = px_valid_r;
  assign bus.pxIndex   = px_index_r;
  assign bus.pxData    = px_data_r;
  assign bus.frameDone = frame_done_r;
  assign bus.frameLen  = frame_len_r;
  assign bus.frameErr  = frame_err_r;
  assign bus.busy      = busy_r;
  assign bus.rdData    = rd_data_r;
endmodule
